// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue: entry layout and PC step.
package fetch_pkg;

   localparam int INSTR_W    = 32;
   localparam int ENTRY_XLEN = 32;   // PC width used for queue entry typing
   localparam int PC_STEP    = 4;

   typedef struct packed {
      logic [INSTR_W-1:0]    instr;
      logic [ENTRY_XLEN-1:0] pc_plus4;
   } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// DEPTH-entry circular buffer of fetch entries with push, pop and flush.
// Pointers wrap modulo DEPTH; count spans 0..DEPTH. Flush beats push/pop.
module fq_storage
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
)
(
   input  logic      clk,
   input  logic      reset,      // asynchronous, active-low
   input  logic      push,
   input  fq_entry_t push_data,
   input  logic      pop,
   input  logic      flush,
   output fq_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [AW-1:0] rd_ptr_reg;
   logic [AW-1:0] wr_ptr_reg;
   logic [AW:0]   count_reg;
   fq_entry_t     mem_reg [DEPTH];
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count_reg == FULL_COUNT);
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem_reg[rd_ptr_reg];

   // Pointer and occupancy bookkeeping; a flush empties the queue outright.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // One register per entry so the whole queue clears on reset.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            mem_reg[gi] <= '0;
         else if (push_ok && !flush && (wr_ptr_reg == AW'(gi)))
            mem_reg[gi] <= push_data;
      end
   end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generator feeding a DEPTH-entry instruction queue.
// IMEM is read combinationally at pcf; redirects flush the queue and retarget.
// Optional build macro FETCH_QUEUE_STATS_EN adds stall/flush counters.
module fetch_queue_unit
   import fetch_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
)
(
   input  logic            clk,
   input  logic            reset,            // asynchronous, active-low
   output logic [XLEN-1:0] pcf,
   input  logic [31:0]     rdf,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            decode_ready,
   output logic            instr_valid,
   output logic [31:0]     instrd,
   output logic [XLEN-1:0] pcplus4d,
   output logic            redirect_misalign
`ifdef FETCH_QUEUE_STATS_EN
   ,
   output logic [31:0]     stall_cycles,
   output logic [15:0]     flush_count
`endif
);

   logic [XLEN-1:0] pcf_reg;
   logic [XLEN-1:0] pcf_next;
   logic [XLEN-1:0] pc_plus4;
   logic            misalign_reg;
   logic            fetch_fire;
   logic            deq;
   logic            full;
   logic            empty;
   fq_entry_t       push_data;
   fq_entry_t       head;

   assign pc_plus4   = pcf_reg + XLEN'(PC_STEP);
   assign fetch_fire = !full && !redirect;
   assign deq        = instr_valid && decode_ready && !redirect;

   assign push_data.instr    = rdf;
   assign push_data.pc_plus4 = ENTRY_XLEN'(pc_plus4);

   fq_storage #(
      .DEPTH (DEPTH)
   ) u_storage (
      .clk       (clk),
      .reset     (reset),
      .push      (fetch_fire),
      .push_data (push_data),
      .pop       (deq),
      .flush     (redirect),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   // Next fetch address: redirect wins, otherwise step only when a push happens.
   always_comb begin
      pcf_next = pcf_reg;
      if (redirect)
         pcf_next = {redirect_target[XLEN-1:2], 2'b00};
      else if (fetch_fire)
         pcf_next = pc_plus4;
   end

   // PC register and the one-cycle misaligned-redirect flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcf_reg      <= RESET_PC;
         misalign_reg <= 1'b0;
      end else begin
         pcf_reg      <= pcf_next;
         misalign_reg <= redirect && (redirect_target[1:0] != 2'b00);
      end
   end

   assign pcf               = pcf_reg;
   assign redirect_misalign = misalign_reg;
   assign instr_valid       = !empty;
   assign instrd            = head.instr;
   assign pcplus4d          = XLEN'(head.pc_plus4);

`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0] stall_cycles_reg;
   logic [15:0] flush_count_reg;

   // Saturating counters for back-pressure stalls and redirect flushes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cycles_reg <= '0;
         flush_count_reg  <= '0;
      end else begin
         if (full && !decode_ready && (stall_cycles_reg != '1))
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         if (redirect && (flush_count_reg != '1))
            flush_count_reg <= flush_count_reg + 16'd1;
      end
   end

   assign stall_cycles = stall_cycles_reg;
   assign flush_count  = flush_count_reg;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit (DEPTH=4, RESET_PC=0).
// IMEM model returns pcf ^ 32'hA5A5_0000. A queue scoreboard tracks expected
// head entries; a vector table adds hand-derived pcf/head expectations.
module tb_fetch_queue_unit;
   import fetch_pkg::*;

   localparam int          XLEN     = 32;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] KEY      = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pcf;
   logic [31:0] rdf;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        decode_ready;
   logic        instr_valid;
   logic [31:0] instrd;
   logic [31:0] pcplus4d;
   logic        redirect_misalign;
`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0] stall_cycles;
   logic [15:0] flush_count;
   logic [31:0] m_stall;
   logic [15:0] m_flush;
`endif

   always #5 clk = ~clk;

   // Combinational IMEM model
   assign rdf = pcf ^ KEY;

   fetch_queue_unit #(
      .XLEN     (XLEN),
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .pcf               (pcf),
      .rdf               (rdf),
      .redirect          (redirect),
      .redirect_target   (redirect_target),
      .decode_ready      (decode_ready),
      .instr_valid       (instr_valid),
      .instrd            (instrd),
      .pcplus4d          (pcplus4d),
      .redirect_misalign (redirect_misalign)
`ifdef FETCH_QUEUE_STATS_EN
      ,
      .stall_cycles      (stall_cycles),
      .flush_count       (flush_count)
`endif
   );

   typedef struct {
      logic        dr;
      logic        rd;
      logic [31:0] tgt;
      logic [31:0] exp_pcf;
      logic        exp_valid;
      logic [31:0] exp_pc4;
      logic        exp_mis;
   } vec_t;

   vec_t        vecs [20];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   fq_entry_t   sb [$];
   logic [31:0] m_pc;
   logic        m_mis;

   function automatic vec_t mk(input logic dr, input logic rd, input logic [31:0] tgt,
                               input logic [31:0] epc, input logic ev,
                               input logic [31:0] e4, input logic em);
      vec_t v;
      v.dr = dr; v.rd = rd; v.tgt = tgt;
      v.exp_pcf = epc; v.exp_valid = ev; v.exp_pc4 = e4; v.exp_mis = em;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, advance the reference model, then compare.
   task automatic cycle(input logic dr, input logic rd, input logic [31:0] tgt);
      logic      was_full;
      fq_entry_t e;
      decode_ready    = dr;
      redirect        = rd;
      redirect_target = tgt;
      was_full = (sb.size() == DEPTH);
`ifdef FETCH_QUEUE_STATS_EN
      if (was_full && !dr && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (rd && m_flush != 16'hFFFF) m_flush++;
`endif
      if (rd) begin
         sb.delete();
         m_pc  = {tgt[31:2], 2'b00};
         m_mis = (tgt[1:0] != 2'b00);
      end else begin
         m_mis = 1'b0;
         if (sb.size() != 0 && dr) void'(sb.pop_front());
         if (!was_full) begin
            e.instr    = m_pc ^ KEY;
            e.pc_plus4 = m_pc + 32'd4;
            sb.push_back(e);
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check("pcf", pcf, m_pc);
      check("instr_valid", 32'(instr_valid), 32'(sb.size() != 0));
      check("redirect_misalign", 32'(redirect_misalign), 32'(m_mis));
      if (sb.size() != 0) begin
         check("sb_instrd", instrd, sb[0].instr);
         check("sb_pcplus4d", pcplus4d, sb[0].pc_plus4);
      end
      $display("cyc %0d dr=%b redir=%b tgt=%h -> pcf=%h valid=%b instrd=%h pcplus4d=%h mis=%b",
               cyc, dr, rd, tgt, pcf, instr_valid, instrd, pcplus4d, redirect_misalign);
   endtask

   initial begin
      // Fill / stall / drain / redirect / misalign / PC wrap vectors
      vecs[0]  = mk(0, 0, 32'h0,         32'h4,         1, 32'h4,   0);
      vecs[1]  = mk(0, 0, 32'h0,         32'h8,         1, 32'h4,   0);
      vecs[2]  = mk(0, 0, 32'h0,         32'hC,         1, 32'h4,   0);
      vecs[3]  = mk(0, 0, 32'h0,         32'h10,        1, 32'h4,   0);
      vecs[4]  = mk(0, 0, 32'h0,         32'h10,        1, 32'h4,   0);
      vecs[5]  = mk(0, 0, 32'h0,         32'h10,        1, 32'h4,   0);
      vecs[6]  = mk(1, 0, 32'h0,         32'h10,        1, 32'h8,   0);
      vecs[7]  = mk(1, 0, 32'h0,         32'h14,        1, 32'hC,   0);
      vecs[8]  = mk(1, 0, 32'h0,         32'h18,        1, 32'h10,  0);
      vecs[9]  = mk(1, 0, 32'h0,         32'h1C,        1, 32'h14,  0);
      vecs[10] = mk(0, 0, 32'h0,         32'h20,        1, 32'h14,  0);
      vecs[11] = mk(0, 0, 32'h0,         32'h20,        1, 32'h14,  0);
      vecs[12] = mk(0, 1, 32'h400,       32'h400,       0, 32'h0,   0);
      vecs[13] = mk(1, 0, 32'h0,         32'h404,       1, 32'h404, 0);
      vecs[14] = mk(1, 1, 32'h203,       32'h200,       0, 32'h0,   1);
      vecs[15] = mk(1, 0, 32'h0,         32'h204,       1, 32'h204, 0);
      vecs[16] = mk(1, 0, 32'h0,         32'h208,       1, 32'h208, 0);
      vecs[17] = mk(1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h0,   0);
      vecs[18] = mk(1, 0, 32'h0,         32'h0,         1, 32'h0,   0);
      vecs[19] = mk(1, 0, 32'h0,         32'h4,         1, 32'h4,   0);

      reset           = 1'b1;
      decode_ready    = 1'b0;
      redirect        = 1'b0;
      redirect_target = '0;
      m_pc            = RESET_PC;
      m_mis           = 1'b0;
`ifdef FETCH_QUEUE_STATS_EN
      m_stall = '0;
      m_flush = '0;
`endif

      // Asynchronous reset state
      #1 reset = 1'b0;
      #1;
      check("rst_pcf", pcf, RESET_PC);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instrd", instrd, 32'd0);
      check("rst_pcplus4d", pcplus4d, 32'd0);
      check("rst_misalign", 32'(redirect_misalign), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Table-driven vectors
      for (int i = 0; i < 20; i++) begin
         cycle(vecs[i].dr, vecs[i].rd, vecs[i].tgt);
         check($sformatf("vec%0d_pcf", i), pcf, vecs[i].exp_pcf);
         check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_mis", i), 32'(redirect_misalign), 32'(vecs[i].exp_mis));
         if (vecs[i].exp_valid)
            check($sformatf("vec%0d_pc4", i), pcplus4d, vecs[i].exp_pc4);
      end
      check("first_instrd_after_wrap", instrd, 32'h0000_0000 ^ KEY);

      // Steady push+pop with one entry: count stays 1 across pointer wraps
      for (int k = 1; k <= 20; k++) begin
         cycle(1'b1, 1'b0, 32'h0);
         check("steady_pcf", pcf, 32'(4 + 4 * k));
         check("steady_pc4", pcplus4d, 32'(4 + 4 * k));
         check("steady_valid", 32'(instr_valid), 32'd1);
      end

`ifdef FETCH_QUEUE_STATS_EN
      check("stall_cycles", stall_cycles, m_stall);
      check("flush_count", 32'(flush_count), 32'(m_flush));
`endif

      // Build count=3, then reset asynchronously mid-drain
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 32'h0);
      check("pre_reset_count3", 32'(sb.size()), 32'd3);
      #3 reset = 1'b0;
      #1;
      check("async_rst_valid", 32'(instr_valid), 32'd0);
      check("async_rst_pcf", pcf, RESET_PC);
      sb.delete();
      m_pc  = RESET_PC;
      m_mis = 1'b0;
`ifdef FETCH_QUEUE_STATS_EN
      check("rst_stall_cycles", stall_cycles, 32'd0);
      check("rst_flush_count", 32'(flush_count), 32'd0);
      m_stall = '0;
      m_flush = '0;
`endif
      @(posedge clk);
      #1;
      check("held_rst_pcf", pcf, RESET_PC);
      check("held_rst_valid", 32'(instr_valid), 32'd0);
      reset = 1'b1;

      // Restart from RESET_PC
      cycle(1'b1, 1'b0, 32'h0);
      check("restart_pcf", pcf, RESET_PC + 32'd4);
      check("restart_instrd", instrd, RESET_PC ^ KEY);
      check("restart_pc4", pcplus4d, RESET_PC + 32'd4);
      cycle(1'b1, 1'b0, 32'h0);
      check("restart2_pc4", pcplus4d, RESET_PC + 32'd8);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
